sync_dr_snk: RTL and testbench

- Clocked sink terminating one dual-rail asynchronous link and converting its tokens into a synchronous valid/ready stream.
- Successor to the plain completion-detect sink. Adds:
  - both handshake encodings, selected by parameter;
  - rail synchronisers;
  - data decode;
  - a DEPTH-entry token buffer with backpressure.
- Sits at the async-to-sync boundary, feeding synchronous consumers such as memories and debug capture.

---
 rtl/sync_dr_snk.sv | 145 ++++++++++++++
 tb/tb_sync_dr_snk.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_dr_snk.sv
// Dual-rail async link sink: synchronise, decode, buffer into a valid/ready stream.
// Optional illegal-codeword detection under SYNC_DR_SNK_ERR_DET_EN.
module sync_dr_snk #(
  parameter ENC = "TP",
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int RAIL_NUM = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               ack_o,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]     in,
  output logic [WIDTH-1:0]                   out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               err
);

  localparam int  AW    = $clog2(DEPTH);
  localparam int  CW    = AW + 1;
  localparam bit  IS_FP = (ENC == "FP");

  typedef enum logic {WAIT_DATA, ACK_HI} state_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0][RAIL_NUM-1:0] sync_q;
  logic [WIDTH-1:0][RAIL_NUM-1:0] s;
  logic [WIDTH-1:0][RAIL_NUM-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] r1, r0;
  logic             complete, spacer;
  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic             push, pop, space;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // FP reads rail levels; TP reads rail transitions against the last token
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (IS_FP) begin
        r1[i] = s[i][1];
        r0[i] = s[i][0];
      end else begin
        r1[i] = s[i][1] ^ ref_q[i][1];
        r0[i] = s[i][0] ^ ref_q[i][0];
      end
    end
    complete = &(r1 ^ r0);
    spacer   = ~|(r1 | r0);
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign space     = (count_q < CW'(DEPTH)) | pop;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    ref_d   = ref_q;
    push    = 1'b0;
    if (IS_FP) begin
      unique case (state_q)
        WAIT_DATA: begin
          if (complete && space) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK_HI;
          end
        end
        ACK_HI: begin
          if (spacer) begin
            ack_d   = 1'b0;
            state_d = WAIT_DATA;
          end
        end
        default: state_d = WAIT_DATA;
      endcase
    end else if (complete && space) begin
      push  = 1'b1;
      ack_d = ~ack_q;
      ref_d = s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_DATA;
      ack_q   <= 1'b0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ref_q   <= ref_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= r1;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SYNC_DR_SNK_ERR_DET_EN
  logic err_q;

  // both rails of a bit asserted (or both toggled) can never be a legal token
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | (|(r1 & r0));
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ack_o    = ack_q;
  assign count    = count_q;
  assign out_data = mem_q[rd_q];

endmodule

// File: tb/tb_sync_dr_snk.sv
// Directed bench for sync_dr_snk: FP and TP instances.
module tb_sync_dr_snk;

`ifdef SYNC_DR_SNK_ERR_DET_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][1:0] fp_in = '0;
  logic            fp_ack, fp_valid, fp_err;
  logic            fp_ready = 1'b0;
  logic [3:0]      fp_data;
  logic [2:0]      fp_count;

  logic [7:0][1:0] tp_in = '0;
  logic            tp_ack, tp_valid, tp_err;
  logic            tp_ready = 1'b0;
  logic [7:0]      tp_data;
  logic [2:0]      tp_count;
  logic [7:0]      lnk1 = '0, lnk0 = '0;

  int npass = 0;
  int ntot  = 0;

  sync_dr_snk #(.ENC("FP"), .WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) u_fp (
    .clk(clk), .rst(rst), .ack_o(fp_ack), .in(fp_in),
    .out_data(fp_data), .out_valid(fp_valid), .out_ready(fp_ready),
    .count(fp_count), .err(fp_err)
  );

  sync_dr_snk #(.ENC("TP"), .WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) u_tp (
    .clk(clk), .rst(rst), .ack_o(tp_ack), .in(tp_in),
    .out_data(tp_data), .out_valid(tp_valid), .out_ready(tp_ready),
    .count(tp_count), .err(tp_err)
  );

  function automatic logic [3:0][1:0] fp_enc(input logic [3:0] w);
    logic [3:0][1:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fp_ack(input logic v, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      if (fp_ack === v) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic wait_tp_ack(input logic v, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      if (tp_ack === v) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic fp_send_hs(input logic [3:0] w, output bit ok);
    bit a, b;
    fp_in = fp_enc(w);
    wait_fp_ack(1'b1, a);
    fp_in = '0;
    wait_fp_ack(1'b0, b);
    ok = a & b;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    ntot++;
    if (fp_ack !== 1'b0 || fp_valid !== 1'b0 || fp_count !== 3'd0)
      $display("FAIL reset_fp ack=%b valid=%b count=%0d want 0/0/0",
               fp_ack, fp_valid, fp_count);
    else npass++;
    ntot++;
    if (fp_data !== 4'h0 || fp_err !== 1'b0)
      $display("FAIL reset_fp_data data=%h err=%b want 0/0", fp_data, fp_err);
    else npass++;
    ntot++;
    if (tp_ack !== 1'b0 || tp_valid !== 1'b0 || tp_count !== 3'd0 || tp_err !== 1'b0)
      $display("FAIL reset_tp ack=%b valid=%b count=%0d err=%b want 0",
               tp_ack, tp_valid, tp_count, tp_err);
    else npass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fp_latency();
    fp_ready = 1'b1;
    fp_in = fp_enc(4'hA);
    repeat (2) tick();
    ntot++;
    if (fp_valid !== 1'b0 || fp_ack !== 1'b0)
      $display("FAIL fp_early valid=%b ack=%b want 0/0", fp_valid, fp_ack);
    else npass++;
    tick();
    ntot++;
    if (fp_valid !== 1'b1 || fp_data !== 4'hA || fp_ack !== 1'b1)
      $display("FAIL fp_capture valid=%b data=%h ack=%b want 1/a/1",
               fp_valid, fp_data, fp_ack);
    else npass++;
    fp_in = '0;
    tick();
    ntot++;
    if (fp_valid !== 1'b0 || fp_count !== 3'd0)
      $display("FAIL fp_pop valid=%b count=%0d want 0/0", fp_valid, fp_count);
    else npass++;
    tick();
    ntot++;
    if (fp_ack !== 1'b1)
      $display("FAIL fp_ack_hold got %b want 1", fp_ack);
    else npass++;
    tick();
    ntot++;
    if (fp_ack !== 1'b0)
      $display("FAIL fp_ack_fall got %b want 0", fp_ack);
    else npass++;
    fp_ready = 1'b0;
  endtask

  task automatic test_tp();
    logic [7:0] vals [3];
    logic       acks [3];
    bit ok;
    vals = '{8'h5A, 8'hFF, 8'h00};
    acks = '{1'b1, 1'b0, 1'b1};
    tp_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      lnk1 = lnk1 ^ vals[t];
      lnk0 = lnk0 ^ ~vals[t];
      for (int i = 0; i < 8; i++) tp_in[i] = {lnk1[i], lnk0[i]};
      wait_tp_ack(acks[t], ok);
      ntot++;
      if (!ok) $display("FAIL tp_ack_%0d got %b want %b", t, tp_ack, acks[t]);
      else npass++;
    end
    tick();
    ntot++;
    if (tp_count !== 3'd3)
      $display("FAIL tp_count got %0d want 3", tp_count);
    else npass++;
    for (int t = 0; t < 3; t++) begin
      ntot++;
      if (tp_data !== vals[t])
        $display("FAIL tp_data_%0d got %h want %h", t, tp_data, vals[t]);
      else npass++;
      tp_ready = 1'b1;
      tick();
      tp_ready = 1'b0;
    end
    ntot++;
    if (tp_valid !== 1'b0)
      $display("FAIL tp_drained valid=%b want 0", tp_valid);
    else npass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    fp_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      fp_send_hs(4'(t), ok);
      ntot++;
      if (!ok) $display("FAIL bp_hs_%0d ack=%b timed out", t, fp_ack);
      else npass++;
    end
    fp_in = fp_enc(4'h5);
    repeat (6) tick();
    ntot++;
    if (fp_count !== 3'd4 || fp_ack !== 1'b0)
      $display("FAIL bp_full count=%0d ack=%b want 4/0", fp_count, fp_ack);
    else npass++;
    fp_ready = 1'b1;
    tick();
    fp_ready = 1'b0;
    ntot++;
    if (fp_count !== 3'd4 || fp_ack !== 1'b1 || fp_data !== 4'h2)
      $display("FAIL bp_pushpop count=%0d ack=%b data=%h want 4/1/2",
               fp_count, fp_ack, fp_data);
    else npass++;
    fp_in = '0;
    wait_fp_ack(1'b0, ok);
    for (int t = 2; t <= 5; t++) begin
      ntot++;
      if (fp_data !== 4'(t))
        $display("FAIL bp_drain_%0d got %h want %h", t, fp_data, 4'(t));
      else npass++;
      fp_ready = 1'b1;
      tick();
      fp_ready = 1'b0;
    end
    ntot++;
    if (fp_count !== 3'd0)
      $display("FAIL bp_empty count=%0d want 0", fp_count);
    else npass++;
  endtask

  task automatic test_skew();
    logic [3:0][1:0] cur;
    logic [3:0]      tgt;
    bit ok;
    tgt = 4'h6;
    cur = '0;
    fp_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      cur[b] = tgt[b] ? 2'b10 : 2'b01;
      fp_in = cur;
      repeat (3) tick();
      if (b < 3) begin
        ntot++;
        if (fp_count !== 3'd0 || fp_ack !== 1'b0)
          $display("FAIL skew_partial_%0d count=%0d ack=%b want 0/0",
                   b, fp_count, fp_ack);
        else npass++;
      end
    end
    repeat (3) tick();
    ntot++;
    if (fp_count !== 3'd1 || fp_data !== 4'h6)
      $display("FAIL skew_one_push count=%0d data=%h want 1/6", fp_count, fp_data);
    else npass++;
    fp_in = '0;
    wait_fp_ack(1'b0, ok);
    fp_ready = 1'b1;
    tick();
    fp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    fp_ready = 1'b0;
    fp_in = fp_enc(4'h9);
    wait_fp_ack(1'b1, ok);
    ntot++;
    if (!ok) $display("FAIL rmid_ack ack=%b timed out want 1", fp_ack);
    else npass++;
    #2;
    rst = 1'b0;
    tp_in = '0;
    lnk1 = '0;
    lnk0 = '0;
    #1;
    ntot++;
    if (fp_ack !== 1'b0 || fp_count !== 3'd0 || fp_valid !== 1'b0)
      $display("FAIL rmid_async ack=%b count=%0d valid=%b want 0/0/0",
               fp_ack, fp_count, fp_valid);
    else npass++;
    tick();
    rst = 1'b1;
    wait_fp_ack(1'b1, ok);
    ntot++;
    if (!ok || fp_data !== 4'h9 || fp_count !== 3'd1)
      $display("FAIL rmid_recapture ack=%b data=%h count=%0d want 1/9/1",
               fp_ack, fp_data, fp_count);
    else npass++;
    fp_in = '0;
    wait_fp_ack(1'b0, ok);
    fp_ready = 1'b1;
    tick();
    fp_ready = 1'b0;
  endtask

  task automatic test_err();
    logic [3:0][1:0] x;
    bit ok;
    fp_ready = 1'b0;
    x = fp_enc(4'h0);
    x[0] = 2'b11;
    fp_in = x;
    repeat (4) tick();
    ntot++;
    if (fp_err !== ERR_EN)
      $display("FAIL err_set got %b want %b", fp_err, ERR_EN);
    else npass++;
    ntot++;
    if (fp_count !== 3'd0 || fp_ack !== 1'b0)
      $display("FAIL err_nopush count=%0d ack=%b want 0/0", fp_count, fp_ack);
    else npass++;
    fp_in = '0;
    repeat (3) tick();
    fp_send_hs(4'h3, ok);
    ntot++;
    if (!ok || fp_count !== 3'd1 || fp_data !== 4'h3)
      $display("FAIL err_legal ok=%b count=%0d data=%h want 1/1/3",
               ok, fp_count, fp_data);
    else npass++;
    ntot++;
    if (fp_err !== ERR_EN)
      $display("FAIL err_sticky got %b want %b", fp_err, ERR_EN);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_fp_latency();
    test_tp();
    test_backpressure();
    test_skew();
    test_reset_mid();
    test_err();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
